// File: rtl/arbiter_param.sv
`default_nettype none
// ============================================================================
//  Module   : arbiter_param
//  Purpose  : N-way request/grant arbiter with fixed/round-robin policy,
//             maximum-hold timeout and gap-free grant handover.
//  Revision : 1.0
// ============================================================================
module arbiter_param #(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 8,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               mode,
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_valid,
  output logic [ID_W-1:0]    gnt_id
);

  localparam int             CNT_W     = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam bit             HOLD_EN   = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] HOLD_LAST = HOLD_EN ? CNT_W'(MAX_HOLD - 1) : '0;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_GRANT = 1'b1} state_t;

  state_t             state, state_n;
  logic [NUM_REQ-1:0] gnt_n;
  logic [ID_W-1:0]    gnt_id_n;
  logic [ID_W-1:0]    rr_ptr, rr_ptr_n;
  logic [CNT_W-1:0]   hold_cnt, hold_cnt_n;

  logic               owner_req;
  logic               expire;
  logic               keep;
  logic [NUM_REQ-1:0] cand;
  logic               lo_found, hi_found;
  logic [ID_W-1:0]    lo_idx, hi_idx;
  logic               win_found;
  logic [ID_W-1:0]    win_idx;

  assign owner_req = req[gnt_id];
  assign expire    = HOLD_EN && (hold_cnt == HOLD_LAST);
  assign keep      = (state == S_GRANT) && owner_req && !expire;
  // On expiry the current owner sits out this one decision.
  assign cand      = ((state == S_GRANT) && owner_req) ? (req & ~gnt) : req;

  // Round-robin = lowest request above rr_ptr, else lowest request overall.
  always_comb begin
    lo_found = 1'b0;
    lo_idx   = '0;
    hi_found = 1'b0;
    hi_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (cand[i]) begin
        lo_found = 1'b1;
        lo_idx   = ID_W'(i);
        if (ID_W'(i) > rr_ptr) begin
          hi_found = 1'b1;
          hi_idx   = ID_W'(i);
        end
      end
    end
    win_found = lo_found;
    win_idx   = (mode && hi_found) ? hi_idx : lo_idx;
  end

  always_comb begin
    state_n    = state;
    gnt_n      = gnt;
    gnt_id_n   = gnt_id;
    rr_ptr_n   = rr_ptr;
    hold_cnt_n = hold_cnt;
    if (keep) begin
      if (HOLD_EN && (hold_cnt != HOLD_LAST)) begin
        hold_cnt_n = hold_cnt + CNT_W'(1);
      end
    end else if (win_found) begin
      state_n    = S_GRANT;
      gnt_n      = NUM_REQ'(1) << win_idx;
      gnt_id_n   = win_idx;
      rr_ptr_n   = win_idx;
      hold_cnt_n = '0;
    end else if ((state == S_GRANT) && owner_req) begin
      // Expired with nobody else waiting: re-grant the same owner, no gap.
      rr_ptr_n   = gnt_id;
      hold_cnt_n = '0;
    end else begin
      state_n    = S_IDLE;
      gnt_n      = '0;
      hold_cnt_n = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      gnt      <= '0;
      gnt_id   <= '0;
      rr_ptr   <= ID_W'(NUM_REQ - 1);
      hold_cnt <= '0;
    end else begin
      state    <= state_n;
      gnt      <= gnt_n;
      gnt_id   <= gnt_id_n;
      rr_ptr   <= rr_ptr_n;
      hold_cnt <= hold_cnt_n;
    end
  end

  assign gnt_valid = |gnt;

endmodule
`default_nettype wire

// File: tb/tb_arbiter_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_arbiter_param
//  Purpose  : Self-checking bench; three arbiters (MAX_HOLD 0/2/3) share
//             stimulus and are compared against a cycle-level reference model.
//  Revision : 1.0
// ============================================================================
module tb_arbiter_param;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic       mode;

  logic [3:0] gnt_a [3];
  logic       vld_a [3];
  logic [1:0] id_a  [3];

  int checks = 0;
  int errors = 0;

  // Reference model state: owner index (-1 idle), cycles held, pointer, last id
  int mh     [3] = '{0, 2, 3};
  int m_own  [3];
  int m_held [3];
  int m_ptr  [3];
  int m_id   [3];

  for (genvar k = 0; k < 3; k++) begin : g_dut
    arbiter_param #(
      .NUM_REQ  (4),
      .MAX_HOLD ((k == 0) ? 0 : ((k == 1) ? 2 : 3))
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .mode      (mode),
      .gnt       (gnt_a[k]),
      .gnt_valid (vld_a[k]),
      .gnt_id    (id_a[k])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d got %0h expected %0h at %0t", tag, k, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] c, input logic m, input int p);
    if (!m) begin
      for (int i = 0; i < 4; i++) if (c[i]) return i;
    end else begin
      for (int s = 1; s <= 4; s++) if (c[(p + s) % 4]) return (p + s) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_own[k] = -1; m_held[k] = 0; m_ptr[k] = 3; m_id[k] = 0;
    end
  endtask

  task automatic model_edge(input int k, input logic [3:0] r, input logic m);
    logic [3:0] c;
    int         w;
    bit         expired;
    if (m_own[k] >= 0 && r[m_own[k]] && !(mh[k] != 0 && m_held[k] == mh[k])) begin
      m_held[k]++;
      return;
    end
    expired = (m_own[k] >= 0) && r[m_own[k]];
    c = r;
    if (expired) c[m_own[k]] = 1'b0;
    w = pick(c, m, m_ptr[k]);
    if (w < 0 && expired) w = m_own[k];
    if (w < 0) begin
      m_own[k] = -1;
    end else begin
      m_own[k] = w; m_held[k] = 1; m_ptr[k] = w; m_id[k] = w;
    end
  endtask

  task automatic check_all(input string tag);
    logic [3:0] eg;
    for (int k = 0; k < 3; k++) begin
      eg = (m_own[k] < 0) ? 4'b0000 : (4'b0001 << m_own[k]);
      check_eq({tag, ".gnt"}, k, 32'(gnt_a[k]), 32'(eg));
      check_eq({tag, ".valid"}, k, 32'(vld_a[k]), 32'(m_own[k] >= 0));
      check_eq({tag, ".id"}, k, 32'(id_a[k]), 32'(m_id[k]));
    end
  endtask

  task automatic step(input logic [3:0] r, input logic m, input string tag);
    @(negedge clk);
    req  = r;
    mode = m;
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_edge(k, r, m);
    #1;
    check_all(tag);
  endtask

  // Asynchronous reset pulse placed between edges
  task automatic mid_reset();
    #2 reset = 1'b1;
    #1;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      check_eq("rst.gnt", k, 32'(gnt_a[k]), 32'h0);
      check_eq("rst.valid", k, 32'(vld_a[k]), 32'h0);
      check_eq("rst.id", k, 32'(id_a[k]), 32'h0);
    end
    #1 reset = 1'b0;
  endtask

  initial begin
    logic [3:0] r;
    logic       m;
    reset = 1'b1;
    req   = 4'b0000;
    mode  = 1'b0;
    model_reset();
    #1;
    check_all("reset");
    #2 reset = 1'b0;

    // Latency and reset mid-grant
    step(4'b0100, 1'b0, "lat");
    check_eq("lat.gnt", 0, 32'(gnt_a[0]), 32'h4);
    mid_reset();
    step(4'b0100, 1'b0, "postrst");
    check_eq("postrst.gnt", 0, 32'(gnt_a[0]), 32'h4);
    step(4'b0000, 1'b0, "idle");

    // Fixed priority, hold, handover, release
    for (int i = 0; i < 6; i++) step(4'b1010, 1'b0, "fixhold");
    step(4'b1000, 1'b0, "handover");
    check_eq("handover.gnt", 0, 32'(gnt_a[0]), 32'h8);
    step(4'b0000, 1'b0, "release");
    check_eq("release.id", 0, 32'(id_a[0]), 32'h3);

    // Round-robin fairness, then fixed with timeout
    for (int i = 0; i < 10; i++) step(4'b1111, 1'b1, "rr");
    step(4'b0000, 1'b0, "idle2");
    for (int i = 0; i < 8; i++) step(4'b0011, 1'b0, "fixto");
    step(4'b0000, 1'b0, "idle3");

    // Single requester with expiry
    for (int i = 0; i < 10; i++) step(4'b0100, 1'b0, "single");
    check_eq("single.gnt", 2, 32'(gnt_a[2]), 32'h4);
    step(4'b0000, 1'b0, "idle4");

    // Mode switch mid-grant
    mid_reset();
    step(4'b0100, 1'b1, "msw0");
    step(4'b0111, 1'b1, "msw1");
    step(4'b0111, 1'b0, "msw2");
    check_eq("msw.keep", 0, 32'(gnt_a[0]), 32'h4);
    step(4'b0011, 1'b0, "msw3");
    check_eq("msw.fixed", 0, 32'(gnt_a[0]), 32'h1);

    // Randomized traffic
    r = 4'b0000;
    m = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) m = ~m;
      step(r, m, "rand");
      if ($urandom_range(0, 99) == 0) mid_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
